// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: records retiring instructions (instruction, PC,
// sequence number) into a circular history and serves age-indexed reads
// with one cycle of latency. Newest entry is read age 0.
module trace_capture_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 15,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = IW + 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              wb_valid_pulse,
    input  logic [DATA_W-1:0] wb_instruction,
    input  logic [PC_W-1:0]   pc_for_vga,
    input  logic              freeze,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [IW-1:0]     rd_index,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_instruction,
    output logic [PC_W-1:0]   rd_pc,
    output logic [SEQ_W-1:0]  rd_seq,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic [31:0]       retired_total,
    output logic [15:0]       dropped_count
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [IW-1:0]     wr_ptr;
    logic [SEQ_W-1:0]  seq;
    logic              pulse_q;
    // Armed only once the strobe has been seen low after reset, so a strobe
    // that is already high when reset releases does not count as an edge.
    logic              armed;
    logic              evt;
    logic              cap;
    logic [IW-1:0]     rd_addr;
    logic              rd_hit;

    assign evt     = wb_valid_pulse & ~pulse_q & armed;
    assign cap     = evt & ~freeze & ~clear & ~reset;
    assign rd_addr = wr_ptr - IW'(1) - rd_index;
    assign rd_hit  = ({1'b0, rd_index} < count);
    assign full    = (count == CW'(DEPTH));

    // Trace storage: written on capture only, never reset or touched by reads.
    always_ff @(posedge CLOCK_50) begin
        if (cap)
            mem[wr_ptr] <= '{instr: wb_instruction, pc: pc_for_vga, seq: seq};
    end

    // Control, counters and registered read port.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pulse_q        <= 1'b0;
            armed          <= 1'b0;
            wr_ptr         <= '0;
            seq            <= '0;
            count          <= '0;
            retired_total  <= '0;
            dropped_count  <= '0;
            rd_valid       <= 1'b0;
            rd_instruction <= '0;
            rd_pc          <= '0;
            rd_seq         <= '0;
        end else begin
            pulse_q <= wb_valid_pulse;
            if (!wb_valid_pulse)
                armed <= 1'b1;

            // Read sees pre-capture state; misses return zeroed fields.
            rd_valid <= rd_req;
            if (rd_req) begin
                if (rd_hit) begin
                    rd_instruction <= mem[rd_addr].instr;
                    rd_pc          <= mem[rd_addr].pc;
                    rd_seq         <= mem[rd_addr].seq;
                end else begin
                    rd_instruction <= '0;
                    rd_pc          <= '0;
                    rd_seq         <= '0;
                end
            end

            if (evt)
                retired_total <= retired_total + 32'd1;

            // Clear wins over capture and the lost event is not a drop.
            if (clear) begin
                count  <= '0;
                wr_ptr <= '0;
            end else if (evt && freeze) begin
                if (dropped_count != 16'hFFFF)
                    dropped_count <= dropped_count + 16'd1;
            end else if (evt) begin
                wr_ptr <= wr_ptr + IW'(1);
                seq    <= seq + SEQ_W'(1);
                if (!full)
                    count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: directed stimulus, read responses checked
// against a queue of hand-computed expectations by a separate monitor.
module tb_trace_capture_buffer;

    localparam int DATA_W = 32;
    localparam int PC_W   = 15;
    localparam int DEPTH  = 8;
    localparam int SEQ_W  = 16;
    localparam int IW     = $clog2(DEPTH);
    localparam int CW     = IW + 1;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [SEQ_W-1:0]  seq;
    } exp_t;

    logic              CLOCK_50 = 1'b0;
    logic              reset = 1'b1;
    logic              wb_valid_pulse = 1'b0;
    logic [DATA_W-1:0] wb_instruction = '0;
    logic [PC_W-1:0]   pc_for_vga = '0;
    logic              freeze = 1'b0;
    logic              clear = 1'b0;
    logic              rd_req = 1'b0;
    logic [IW-1:0]     rd_index = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_instruction;
    logic [PC_W-1:0]   rd_pc;
    logic [SEQ_W-1:0]  rd_seq;
    logic [CW-1:0]     count;
    logic              full;
    logic [31:0]       retired_total;
    logic [15:0]       dropped_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    trace_capture_buffer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .wb_valid_pulse (wb_valid_pulse),
        .wb_instruction (wb_instruction),
        .pc_for_vga     (pc_for_vga),
        .freeze         (freeze),
        .clear          (clear),
        .rd_req         (rd_req),
        .rd_index       (rd_index),
        .rd_valid       (rd_valid),
        .rd_instruction (rd_instruction),
        .rd_pc          (rd_pc),
        .rd_seq         (rd_seq),
        .count          (count),
        .full           (full),
        .retired_total  (retired_total),
        .dropped_count  (dropped_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge CLOCK_50) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got response with no outstanding read");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rd_instruction", rd_instruction, e.instr);
                check("rd_pc", 32'(rd_pc), 32'(e.pc));
                check("rd_seq", 32'(rd_seq), 32'(e.seq));
            end
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    // One retirement strobe: high for one cycle, then low for one cycle.
    task automatic ev(input logic [31:0] instr, input logic [14:0] pc,
                      input logic frz, input logic clr);
        @(negedge CLOCK_50);
        wb_valid_pulse = 1'b1;
        wb_instruction = instr;
        pc_for_vga     = pc;
        freeze         = frz;
        clear          = clr;
        @(negedge CLOCK_50);
        wb_valid_pulse = 1'b0;
        freeze         = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [31:0] instr,
                      input logic [14:0] pc, input logic [15:0] s);
        @(negedge CLOCK_50);
        rd_req   = 1'b1;
        rd_index = IW'(idx);
        sb_q.push_back('{instr: instr, pc: pc, seq: s});
        @(negedge CLOCK_50);
        rd_req = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        // Reset with the strobe held high and a read request pending.
        wb_valid_pulse = 1'b1;
        rd_req         = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_retired_held_high", retired_total, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);
        wb_valid_pulse = 1'b0;
        rd(0, 32'h0, 15'd0, 16'd0);

        // Fill
        ev(32'hA1, 15'd1, 0, 0);
        ev(32'hA2, 15'd2, 0, 0);
        ev(32'hA3, 15'd3, 0, 0);
        check("fill_count", 32'(count), 32'd3);
        rd(0, 32'hA3, 15'd3, 16'd2);
        rd(1, 32'hA2, 15'd2, 16'd1);
        rd(2, 32'hA1, 15'd1, 16'd0);
        rd(3, 32'h0, 15'd0, 16'd0);

        // Wrap
        do_reset();
        for (int i = 0; i < 10; i++) ev(32'h100 + 32'(i), 15'(i), 0, 0);
        check("wrap_count", 32'(count), 32'd8);
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_retired", retired_total, 32'd10);
        rd(0, 32'h109, 15'd9, 16'd9);
        rd(7, 32'h102, 15'd2, 16'd2);

        // Freeze
        do_reset();
        ev(32'hBAD0, 15'd4, 1, 0);
        ev(32'hBAD1, 15'd4, 1, 0);
        ev(32'hB0, 15'd5, 0, 0);
        check("frz_dropped", 32'(dropped_count), 32'd2);
        check("frz_count", 32'(count), 32'd1);
        check("frz_retired", retired_total, 32'd3);
        rd(0, 32'hB0, 15'd5, 16'd0);
        rd(1, 32'h0, 15'd0, 16'd0);

        // Held strobe
        do_reset();
        @(negedge CLOCK_50);
        wb_valid_pulse = 1'b1;
        wb_instruction = 32'hC0;
        pc_for_vga     = 15'd7;
        repeat (5) @(negedge CLOCK_50);
        wb_valid_pulse = 1'b0;
        @(negedge CLOCK_50);
        check("held_count", 32'(count), 32'd1);
        check("held_retired", retired_total, 32'd1);
        rd(0, 32'hC0, 15'd7, 16'd0);

        // Clear coincident with an event
        do_reset();
        for (int i = 0; i < 4; i++) ev(32'hD0 + 32'(i), 15'(i), 0, 0);
        ev(32'hEE, 15'd8, 0, 1);
        check("clr_count", 32'(count), 32'd0);
        check("clr_dropped", 32'(dropped_count), 32'd0);
        check("clr_retired", retired_total, 32'd5);
        check("clr_full", 32'(full), 32'd0);
        rd(0, 32'h0, 15'd0, 16'd0);
        ev(32'hF0, 15'd9, 0, 0);
        check("clr_after_count", 32'(count), 32'd1);
        rd(0, 32'hF0, 15'd9, 16'd4);

        // Read coincident with a capture
        do_reset();
        ev(32'h10, 15'd1, 0, 0);
        ev(32'h11, 15'd2, 0, 0);
        @(negedge CLOCK_50);
        wb_valid_pulse = 1'b1;
        wb_instruction = 32'h12;
        pc_for_vga     = 15'd3;
        rd_req         = 1'b1;
        rd_index       = '0;
        sb_q.push_back('{instr: 32'h11, pc: 15'd2, seq: 16'd1});
        @(negedge CLOCK_50);
        wb_valid_pulse = 1'b0;
        rd_req         = 1'b0;
        rd(0, 32'h12, 15'd3, 16'd2);
        check("rdw_count", 32'(count), 32'd3);

        repeat (3) @(negedge CLOCK_50);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_capture_buffer.md
TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter PC_W, default 15, program-counter width.
REQ-003 SHALL have parameter DEPTH, default 8, trace entries; power of two, >=2.
REQ-004 SHALL have parameter SEQ_W, default 16, sequence-number width.
REQ-005 SHALL have port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port wb_valid_pulse  in  1  retirement strobe from writeback stage.
REQ-008 SHALL have port wb_instruction  in  DATA_W  retiring instruction.
REQ-009 SHALL have port pc_for_vga  in  PC_W  PC associated with the retiring instruction.
REQ-010 SHALL have port freeze  in  1  suppresses capture while high.
REQ-011 SHALL have port clear  in  1  empties the trace.
REQ-012 SHALL have port rd_req  in  1  read request.
REQ-013 SHALL have port rd_index  in  log2(DEPTH)  read age; 0 = newest entry.
REQ-014 SHALL have port rd_valid  out  1  read response valid/hit.
REQ-015 SHALL have port rd_instruction  out  DATA_W, rd_pc  out  PC_W, rd_seq  out  SEQ_W: read data.
REQ-016 SHALL have port count  out  log2(DEPTH)+1  occupied entries.
REQ-017 SHALL have ports full  out  1, retired_total  out  32, dropped_count  out  16.

Function
REQ-018 SHALL detect a retirement event as a 0->1 transition of wb_valid_pulse (registered previous value); a held-high strobe SHALL yield exactly one event.
REQ-019 SHALL increment retired_total (wrapping at 2^32) on every event, regardless of freeze/clear.
REQ-020 SHALL, on an event with freeze=0 and clear=0, write {wb_instruction, pc_for_vga, seq} at wr_ptr, advance wr_ptr mod DEPTH, and increment seq (wrapping at 2^SEQ_W).
REQ-021 SHALL, when count<DEPTH, increment count on capture; when count=DEPTH, overwrite the oldest entry and keep count=DEPTH.
REQ-022 SHALL drive full=1 exactly when count=DEPTH.
REQ-023 SHALL, on an event with freeze=1, discard the entry and increment dropped_count, saturating at 16'hFFFF.
REQ-024 SHALL, on clear=1, set count=0 and wr_ptr=0 next cycle; stored data, seq, retired_total and dropped_count are unchanged.
REQ-025 SHALL give clear priority over a simultaneous capture: the entry is discarded, not counted as dropped, retired_total still increments.
REQ-026 SHALL return read data one cycle after rd_req=1, addressed at (wr_ptr-1-rd_index) mod DEPTH, using count and wr_ptr as of the request cycle.
REQ-027 SHALL, on a read with rd_index>=count, drive rd_valid=1 with rd_instruction, rd_pc and rd_seq all zero; on a hit, drive rd_valid=1 with the stored fields.
REQ-028 SHALL drive rd_valid=0 in any cycle not following rd_req=1; rd_* data hold the last response.
REQ-029 SHALL, on a read coincident with a capture, return pre-capture contents.
REQ-030 SHALL ignore rd_req during reset and SHALL NOT alter trace contents on any read.

Reset
REQ-031 SHALL, while reset=1, clear count, wr_ptr, seq, retired_total, dropped_count, full, rd_valid, rd_instruction, rd_pc, rd_seq and the edge-detect register to 0.
REQ-032 SHALL NOT require trace storage contents to be cleared; reset mid-capture SHALL discard that event.
REQ-033 SHALL treat wb_valid_pulse already high when reset deasserts as no event until it falls and rises again.

Verification
REQ-034 Fill: 3 events (instr 0xA1,0xA2,0xA3; pc 1,2,3) -> count=3; read idx0 -> 0xA3/pc3/seq2; idx2 -> 0xA1/seq0; idx3 -> rd_valid=1, zeros.
REQ-035 Wrap: 10 events with DEPTH=8 -> count=8, full=1, idx0 seq=9, idx7 seq=2, retired_total=10.
REQ-036 Freeze: 2 events with freeze=1, then 1 with freeze=0 -> dropped_count=2, count=1, idx0 seq=0, retired_total=3.
REQ-037 Held strobe: wb_valid_pulse high 5 cycles -> exactly 1 capture.
REQ-038 Clear+event same cycle after 4 captures -> count=0, dropped_count unchanged, retired_total=5; next event stored with seq=4.
REQ-039 Read-during-write: 2 entries, rd_req idx0 coincident with event -> returns old newest (seq1); next read idx0 -> seq2.
